// File: rtl/srg_mips_pkg.sv
// Shared definitions for the ID/EX stage of the 32-bit MIPS datapath.
// Contents:
//   WIDTH_DEFAULT, REG_ADDR_W_DEFAULT  default datapath / register-number widths
//   op_sel_e                           ALU OperationSelect encodings
//   alu_op_e                           main-decoder ALUOp encodings
//   FUNCT_*                            R-type function-field values the ALU supports
//   ctrl_t                             main-decoder control bits carried into EX
package srg_mips_pkg;

    localparam int WIDTH_DEFAULT      = 32;
    localparam int REG_ADDR_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_sel_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic reg_dst;
    } ctrl_t;

endpackage

// File: rtl/srg_alu_control.sv
// ALU control decoder: maps registered ALUOp/Funct to the ALU's 3-bit
// OperationSelect and flags encodings the ALU cannot execute.
// Ports:
//   alu_op            in   2  main-decoder ALUOp
//   funct             in   6  R-type function field
//   operation_select  out  3  ALU operation (OP_ADD when illegal)
//   illegal_op        out  1  ALUOp/Funct combination is undecodable
module srg_alu_control
    import srg_mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] operation_select,
    output logic       illegal_op
);

    always_comb begin
        // NOTE: both outputs get a default before the case so every path
        // assigns them; leaving one unassigned on some path infers a latch.
        operation_select = OP_ADD;
        illegal_op       = 1'b0;
        case (alu_op)
            ALUOP_ADD: operation_select = OP_ADD;
            ALUOP_SUB: operation_select = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: operation_select = OP_ADD;
                    FUNCT_SUB: operation_select = OP_SUB;
                    FUNCT_AND: operation_select = OP_AND;
                    FUNCT_OR:  operation_select = OP_OR;
                    FUNCT_SLT: operation_select = OP_SLT;
                    default:   illegal_op       = 1'b1;
                endcase
            end
            default: illegal_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/srg_id_ex_stage.sv
// ID/EX pipeline register feeding srg_32Bit_ALU. Latches decoded operands and
// controls, applies EX/MEM and MEM/WB forwarding, and drives the ALU operands
// and OperationSelect. Stall holds the stage; Flush loads a bubble and wins
// over Stall.
// Ports:
//   Clock, Reset                    clock, async active-high reset
//   Stall, Flush                    hazard-unit hold / bubble requests
//   InValid                         ID holds a real instruction
//   RsData, RtData, Imm16           operands from decode
//   Rs, Rt, Rd                      register numbers
//   ALUOp, Funct                    ALU decode inputs
//   ALUSrc .. MemToReg              main-decoder controls
//   ExMem*, MemWb*                  downstream writeback info for forwarding
//   A, B, OperationSelect           ALU inputs
//   StoreData, WriteReg             forwarded Rt / destination register
//   ExRegWrite .. ExMemToReg        registered controls (0 when not Valid)
//   Valid, IllegalOp                stage status
module srg_id_ex_stage
    import srg_mips_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Stall,
    input  logic                  Flush,
    input  logic                  InValid,
    input  logic [WIDTH-1:0]      RsData,
    input  logic [WIDTH-1:0]      RtData,
    input  logic [15:0]           Imm16,
    input  logic [REG_ADDR_W-1:0] Rs,
    input  logic [REG_ADDR_W-1:0] Rt,
    input  logic [REG_ADDR_W-1:0] Rd,
    input  logic [1:0]            ALUOp,
    input  logic [5:0]            Funct,
    input  logic                  ALUSrc,
    input  logic                  RegDst,
    input  logic                  RegWrite,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  MemToReg,
    input  logic                  ExMemRegWrite,
    input  logic                  MemWbRegWrite,
    input  logic [REG_ADDR_W-1:0] ExMemRd,
    input  logic [REG_ADDR_W-1:0] MemWbRd,
    input  logic [WIDTH-1:0]      ExMemResult,
    input  logic [WIDTH-1:0]      MemWbResult,
    output logic [WIDTH-1:0]      A,
    output logic [WIDTH-1:0]      B,
    output logic [2:0]            OperationSelect,
    output logic [WIDTH-1:0]      StoreData,
    output logic [REG_ADDR_W-1:0] WriteReg,
    output logic                  ExRegWrite,
    output logic                  ExMemRead,
    output logic                  ExMemWrite,
    output logic                  ExMemToReg,
    output logic                  Valid,
    output logic                  IllegalOp
);

    logic                  valid_q;
    ctrl_t                 ctrl_q;
    logic [WIDTH-1:0]      rs_data_q;
    logic [WIDTH-1:0]      rt_data_q;
    logic [15:0]           imm16_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [REG_ADDR_W-1:0] rt_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [1:0]            alu_op_q;
    logic [5:0]            funct_q;

    always_ff @(posedge Clock or posedge Reset) begin
        // NOTE: stage state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (Reset) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm16_q   <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            alu_op_q  <= ALUOP_ADD;
            funct_q   <= '0;
        end else if (Flush) begin
            // Bubble: operand registers keep whatever they hold; with Valid
            // low nothing downstream acts on them.
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (!Stall) begin
            valid_q   <= InValid;
            ctrl_q    <= '{reg_write: RegWrite, mem_read: MemRead,
                           mem_write: MemWrite, mem_to_reg: MemToReg,
                           alu_src: ALUSrc, reg_dst: RegDst};
            rs_data_q <= RsData;
            rt_data_q <= RtData;
            imm16_q   <= Imm16;
            rs_q      <= Rs;
            rt_q      <= Rt;
            rd_q      <= Rd;
            alu_op_q  <= ALUOp;
            funct_q   <= Funct;
        end
    end

    // Forwarding: the younger EX/MEM result beats MEM/WB; $zero never forwards.
    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

    always_comb begin
        fwd_rs = rs_data_q;
        if (rs_q != '0 && ExMemRegWrite && ExMemRd == rs_q)
            fwd_rs = ExMemResult;
        else if (rs_q != '0 && MemWbRegWrite && MemWbRd == rs_q)
            fwd_rs = MemWbResult;

        fwd_rt = rt_data_q;
        if (rt_q != '0 && ExMemRegWrite && ExMemRd == rt_q)
            fwd_rt = ExMemResult;
        else if (rt_q != '0 && MemWbRegWrite && MemWbRd == rt_q)
            fwd_rt = MemWbResult;
    end

    logic illegal_raw;

    srg_alu_control u_alu_control (
        .alu_op           (alu_op_q),
        .funct            (funct_q),
        .operation_select (OperationSelect),
        .illegal_op       (illegal_raw)
    );

    assign A         = fwd_rs;
    assign B         = ctrl_q.alu_src ? {{(WIDTH-16){imm16_q[15]}}, imm16_q} : fwd_rt;
    assign StoreData = fwd_rt;
    assign WriteReg  = ctrl_q.reg_dst ? rd_q : rt_q;

    // An undecodable op must not write state; MemToReg only selects a mux.
    assign Valid      = valid_q;
    assign IllegalOp  = valid_q & illegal_raw;
    assign ExRegWrite = valid_q & ctrl_q.reg_write & ~illegal_raw;
    assign ExMemRead  = valid_q & ctrl_q.mem_read  & ~illegal_raw;
    assign ExMemWrite = valid_q & ctrl_q.mem_write & ~illegal_raw;
    assign ExMemToReg = valid_q & ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_srg_id_ex_stage.sv
// Self-checking bench for srg_id_ex_stage: directed scenarios plus a
// randomized run compared against a behavioural model of the stage.
module tb_srg_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [15:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } id_t;

    typedef struct packed {
        logic        ex_we;
        logic [4:0]  ex_rd;
        logic [31:0] ex_res;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
    } ds_t;

    typedef struct packed {
        logic        valid;
        logic        illegal;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
        logic [4:0]  wr;
    } out_t;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic Stall = 1'b0;
    logic Flush = 1'b0;
    id_t  id_in = '0;
    ds_t  ds    = '0;

    logic [31:0] A, B, StoreData;
    logic [2:0]  OperationSelect;
    logic [4:0]  WriteReg;
    logic        ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, Valid, IllegalOp;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clock = ~Clock;

    srg_id_ex_stage dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .Stall           (Stall),
        .Flush           (Flush),
        .InValid         (id_in.valid),
        .RsData          (id_in.rs_data),
        .RtData          (id_in.rt_data),
        .Imm16           (id_in.imm),
        .Rs              (id_in.rs),
        .Rt              (id_in.rt),
        .Rd              (id_in.rd),
        .ALUOp           (id_in.alu_op),
        .Funct           (id_in.funct),
        .ALUSrc          (id_in.alu_src),
        .RegDst          (id_in.reg_dst),
        .RegWrite        (id_in.reg_write),
        .MemRead         (id_in.mem_read),
        .MemWrite        (id_in.mem_write),
        .MemToReg        (id_in.mem_to_reg),
        .ExMemRegWrite   (ds.ex_we),
        .MemWbRegWrite   (ds.wb_we),
        .ExMemRd         (ds.ex_rd),
        .MemWbRd         (ds.wb_rd),
        .ExMemResult     (ds.ex_res),
        .MemWbResult     (ds.wb_res),
        .A               (A),
        .B               (B),
        .OperationSelect (OperationSelect),
        .StoreData       (StoreData),
        .WriteReg        (WriteReg),
        .ExRegWrite      (ExRegWrite),
        .ExMemRead       (ExMemRead),
        .ExMemWrite      (ExMemWrite),
        .ExMemToReg      (ExMemToReg),
        .Valid           (Valid),
        .IllegalOp       (IllegalOp)
    );

    out_t dut_o;
    assign dut_o = {Valid, IllegalOp, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg,
                    OperationSelect, A, B, StoreData, WriteReg};

    // ---------------- reference model ----------------
    // The instruction the model believes is sitting in EX.
    id_t ex_m = '0;

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ex_m <= '0;
        end else if (Flush) begin
            ex_m.valid      <= 1'b0;
            ex_m.reg_write  <= 1'b0;
            ex_m.mem_read   <= 1'b0;
            ex_m.mem_write  <= 1'b0;
            ex_m.mem_to_reg <= 1'b0;
        end else if (!Stall) begin
            ex_m <= id_in;
        end
    end

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v, input ds_t d);
        if (r == 5'd0) return v;
        if (d.ex_we && d.ex_rd == r) return d.ex_res;
        if (d.wb_we && d.wb_rd == r) return d.wb_res;
        return v;
    endfunction

    function automatic out_t model(input id_t e, input ds_t d);
        out_t        o;
        logic        ill;
        logic [31:0] rt_val;
        o   = '0;
        ill = 1'b0;
        o.op = 3'b010;
        if (e.alu_op == 2'b01) o.op = 3'b110;
        else if (e.alu_op == 2'b11) ill = 1'b1;
        else if (e.alu_op == 2'b10) begin
            if      (e.funct == 6'd32) o.op = 3'b010;
            else if (e.funct == 6'd34) o.op = 3'b110;
            else if (e.funct == 6'd36) o.op = 3'b000;
            else if (e.funct == 6'd37) o.op = 3'b001;
            else if (e.funct == 6'd42) o.op = 3'b111;
            else ill = 1'b1;
        end
        rt_val       = fwd(e.rt, e.rt_data, d);
        o.valid      = e.valid;
        o.illegal    = e.valid && ill;
        o.reg_write  = e.valid && e.reg_write && !ill;
        o.mem_read   = e.valid && e.mem_read && !ill;
        o.mem_write  = e.valid && e.mem_write && !ill;
        o.mem_to_reg = e.valid && e.mem_to_reg;
        o.a          = fwd(e.rs, e.rs_data, d);
        o.b          = e.alu_src ? 32'($signed(e.imm)) : rt_val;
        o.store      = rt_val;
        o.wr         = e.reg_dst ? e.rd : e.rt;
        return o;
    endfunction

    function automatic id_t base();
        id_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.alu_op    = 2'b10;
        r.funct     = 6'b100000;
        r.rs        = 5'd1;
        r.rt        = 5'd2;
        r.rd        = 5'd3;
        r.reg_dst   = 1'b1;
        r.reg_write = 1'b1;
        return r;
    endfunction

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1;
        id_in = '0;
        ds    = '0;
        repeat (2) @(posedge Clock);
        #1;
        n_checks++;
        if ({Valid, IllegalOp, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg} !== 6'b0)
            $display("FAIL reset_ctrl: got %b want 000000",
                     {Valid, IllegalOp, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg});
        else n_pass++;
        n_checks++;
        if ({OperationSelect, A, B, StoreData, WriteReg} !== {3'b010, 101'd0})
            $display("FAIL reset_data: got op=%b A=%h B=%h SD=%h WR=%0d want op=010 zeros",
                     OperationSelect, A, B, StoreData, WriteReg);
        else n_pass++;

        @(negedge Clock);
        Reset = 1'b0;
        id_in = base();
        id_in.funct = 6'b100010;
        cycle();
        n_checks++;
        if ({Valid, OperationSelect, ExRegWrite} !== 5'b1_110_1)
            $display("FAIL load_sub: got V=%b op=%b RW=%b want 1 110 1", Valid, OperationSelect, ExRegWrite);
        else n_pass++;

        // Asynchronous reset in the low phase, checked before any clock edge.
        @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if ({Valid, OperationSelect, ExRegWrite} !== 5'b0_010_0)
            $display("FAIL async_reset: got V=%b op=%b RW=%b want 0 010 0", Valid, OperationSelect, ExRegWrite);
        else n_pass++;

        @(negedge Clock);
        Reset = 1'b0;
        id_in = base();
        id_in.funct   = 6'b100100;
        id_in.rs_data = 32'h0000_AAAA;
        id_in.rt_data = 32'h0000_5555;
        cycle();
        n_checks++;
        if ({Valid, OperationSelect, A, B} !== {1'b1, 3'b000, 32'h0000_AAAA, 32'h0000_5555})
            $display("FAIL and_after_reset: got V=%b op=%b A=%h B=%h want 1 000 0000aaaa 00005555",
                     Valid, OperationSelect, A, B);
        else n_pass++;
    endtask

    task automatic test_immediate();
        id_in = base();
        id_in.alu_src = 1'b1;
        id_in.alu_op  = 2'b00;
        id_in.imm     = 16'hFFF0;
        cycle();
        n_checks++;
        if ({OperationSelect, B} !== {3'b010, 32'hFFFF_FFF0})
            $display("FAIL imm_neg: got op=%b B=%h want 010 fffffff0", OperationSelect, B);
        else n_pass++;
        id_in.imm = 16'h0148;
        cycle();
        n_checks++;
        if ({OperationSelect, B} !== {3'b010, 32'h0000_0148})
            $display("FAIL imm_pos: got op=%b B=%h want 010 00000148", OperationSelect, B);
        else n_pass++;
    endtask

    task automatic test_forwarding();
        ds    = '0;
        id_in = base();
        id_in.rs      = 5'd5;
        id_in.rt      = 5'd5;
        id_in.rs_data = 32'h0BAD_0001;
        id_in.rt_data = 32'h0BAD_0002;
        cycle();
        ds = '{ex_we: 1'b1, ex_rd: 5'd5, ex_res: 32'h1111,
               wb_we: 1'b1, wb_rd: 5'd5, wb_res: 32'h2222};
        #1;
        n_checks++;
        if ({A, B} !== {32'h1111, 32'h1111})
            $display("FAIL fwd_exmem: got A=%h B=%h want 00001111 00001111", A, B);
        else n_pass++;
        ds.ex_we = 1'b0;
        #1;
        n_checks++;
        if ({A, B} !== {32'h2222, 32'h2222})
            $display("FAIL fwd_memwb: got A=%h B=%h want 00002222 00002222", A, B);
        else n_pass++;

        id_in.rs      = 5'd0;
        id_in.rs_data = 32'hCAFE_0001;
        ds = '{ex_we: 1'b1, ex_rd: 5'd0, ex_res: 32'h1111,
               wb_we: 1'b1, wb_rd: 5'd0, wb_res: 32'h2222};
        cycle();
        n_checks++;
        if (A !== 32'hCAFE_0001)
            $display("FAIL fwd_zero: got A=%h want cafe0001", A);
        else n_pass++;
        ds = '0;
    endtask

    task automatic test_stall_flush();
        out_t snap;
        ds    = '{ex_we: 1'b1, ex_rd: 5'd20, ex_res: 32'h77, wb_we: 1'b0, wb_rd: 5'd0, wb_res: 32'h0};
        id_in = base();
        id_in.mem_to_reg = 1'b1;
        id_in.rs_data    = 32'h1234_5678;
        id_in.rt_data    = 32'h9ABC_DEF0;
        cycle();
        snap = model(ex_m, ds);
        n_checks++;
        if (Valid !== 1'b1)
            $display("FAIL pre_stall_valid: got %b want 1", Valid);
        else n_pass++;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_in.rs_data = $urandom;
            id_in.rt_data = $urandom;
            id_in.funct   = 6'b100101;
            id_in.rd      = 5'($urandom_range(0, 31));
            id_in.valid   = i[0];
            cycle();
            n_checks++;
            if (dut_o !== snap)
                $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_o, snap);
            else n_pass++;
        end
        Flush = 1'b1;
        cycle();
        n_checks++;
        if ({Valid, IllegalOp, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg} !== 6'b0)
            $display("FAIL flush_over_stall: got %b want 000000",
                     {Valid, IllegalOp, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg});
        else n_pass++;
        Stall = 1'b0;
        Flush = 1'b0;
        ds    = '0;
    endtask

    task automatic test_alu_decode();
        id_in = base();
        id_in.funct = 6'b101010;
        cycle();
        n_checks++;
        if ({OperationSelect, IllegalOp} !== 4'b111_0)
            $display("FAIL slt: got op=%b ill=%b want 111 0", OperationSelect, IllegalOp);
        else n_pass++;

        id_in.funct     = 6'b000000;
        id_in.mem_write = 1'b1;
        cycle();
        n_checks++;
        if ({IllegalOp, ExRegWrite, ExMemWrite, OperationSelect} !== 6'b1_0_0_010)
            $display("FAIL illegal_funct: got ill=%b RW=%b MW=%b op=%b want 1 0 0 010",
                     IllegalOp, ExRegWrite, ExMemWrite, OperationSelect);
        else n_pass++;

        id_in.valid = 1'b0;
        cycle();
        n_checks++;
        if ({IllegalOp, ExRegWrite} !== 2'b00)
            $display("FAIL illegal_invalid: got ill=%b RW=%b want 0 0", IllegalOp, ExRegWrite);
        else n_pass++;

        id_in = base();
        id_in.alu_op = 2'b11;
        cycle();
        n_checks++;
        if ({IllegalOp, OperationSelect} !== 4'b1_010)
            $display("FAIL aluop_rsvd: got ill=%b op=%b want 1 010", IllegalOp, OperationSelect);
        else n_pass++;
    endtask

    task automatic test_writereg_store();
        id_in = base();
        id_in.reg_dst = 1'b0;
        id_in.rt      = 5'd7;
        id_in.rd      = 5'd9;
        cycle();
        n_checks++;
        if (WriteReg !== 5'd7) $display("FAIL writereg_rt: got %0d want 7", WriteReg);
        else n_pass++;
        id_in.reg_dst = 1'b1;
        cycle();
        n_checks++;
        if (WriteReg !== 5'd9) $display("FAIL writereg_rd: got %0d want 9", WriteReg);
        else n_pass++;

        id_in.reg_write = 1'b0;
        id_in.mem_write = 1'b1;
        id_in.alu_op    = 2'b00;
        id_in.alu_src   = 1'b1;
        id_in.imm       = 16'h0010;
        id_in.rt_data   = 32'h5A5A_5A5A;
        ds = '{ex_we: 1'b1, ex_rd: 5'd7, ex_res: 32'h0000_00FF,
               wb_we: 1'b1, wb_rd: 5'd7, wb_res: 32'h0000_DEAD};
        cycle();
        n_checks++;
        if ({StoreData, B, ExMemWrite} !== {32'h0000_00FF, 32'h0000_0010, 1'b1})
            $display("FAIL store_fwd: got SD=%h B=%h MW=%b want 000000ff 00000010 1", StoreData, B, ExMemWrite);
        else n_pass++;
        ds = '0;
    endtask

    task automatic test_random();
        logic [5:0] functs [6];
        out_t e, g;
        functs = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        for (int i = 0; i < 400; i++) begin
            id_t r;
            r.valid      = ($urandom_range(0, 7) != 0);
            r.rs_data    = $urandom;
            r.rt_data    = $urandom;
            r.imm        = 16'($urandom);
            r.rs         = 5'($urandom_range(0, 7));
            r.rt         = 5'($urandom_range(0, 7));
            r.rd         = 5'($urandom_range(0, 31));
            r.alu_op     = 2'($urandom_range(0, 3));
            r.funct      = ($urandom_range(0, 9) == 0) ? 6'($urandom) : functs[$urandom_range(0, 5)];
            r.alu_src    = 1'($urandom);
            r.reg_dst    = 1'($urandom);
            r.reg_write  = 1'($urandom);
            r.mem_read   = 1'($urandom);
            r.mem_write  = 1'($urandom);
            r.mem_to_reg = 1'($urandom);
            id_in = r;
            ds = '{ex_we: 1'($urandom), ex_rd: 5'($urandom_range(0, 7)), ex_res: $urandom,
                   wb_we: 1'($urandom), wb_rd: 5'($urandom_range(0, 7)), wb_res: $urandom};
            Stall = ($urandom_range(0, 7) == 0);
            Flush = ($urandom_range(0, 9) == 0);
            cycle();
            e = model(ex_m, ds);
            g = dut_o;
            if (!e.valid) begin
                e.op = '0; e.a = '0; e.b = '0; e.store = '0; e.wr = '0;
                g.op = '0; g.a = '0; g.b = '0; g.store = '0; g.wr = '0;
            end
            n_checks++;
            if (g !== e) $display("FAIL random[%0d]: got %h want %h", i, g, e);
            else n_pass++;
        end
        Stall = 1'b0;
        Flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_forwarding();
        test_stall_flush();
        test_alu_decode();
        test_writereg_store();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
